// File: rtl/game_flow_controller.sv
// Match sequencer for the two-tank arena: attract, countdown, play, pause,
// round-end and game-over phases, with round-win tallies and score clearing.
module game_flow_controller #(
  parameter int MAX_DEATHS    = 3,
  parameter int GOLD_TO_WIN   = 5,
  parameter int COUNTDOWN_SEC = 3,
  parameter int ROUND_END_SEC = 2,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       tick_1s,
  input  logic [1:0] numOfDeath1,
  input  logic [1:0] numOfDeath2,
  input  logic [2:0] numOfgold1,
  input  logic [2:0] numOfgold2,
  output logic [2:0] phase,
  output logic       play_enable,
  output logic       clear_scores,
  output logic [1:0] countdown,
  output logic [1:0] round_wins1,
  output logic [1:0] round_wins2,
  output logic [1:0] round_winner,
  output logic [1:0] game_winner
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COUNTDOWN = 3'd1;
  localparam logic [2:0] PLAY      = 3'd2;
  localparam logic [2:0] PAUSE     = 3'd3;
  localparam logic [2:0] ROUND_END = 3'd4;
  localparam logic [2:0] GAME_OVER = 3'd5;

  localparam int         RE_LAST_I = ROUND_END_SEC - 1;
  localparam logic [1:0] DEATH_LIM = MAX_DEATHS[1:0];
  localparam logic [2:0] GOLD_LIM  = GOLD_TO_WIN[2:0];
  localparam logic [1:0] CD_INIT   = COUNTDOWN_SEC[1:0];
  localparam logic [3:0] RE_LAST   = RE_LAST_I[3:0];
  localparam logic [1:0] WINS_LIM  = ROUNDS_TO_WIN[1:0];

  logic       start_q;
  logic       pause_q;
  logic       start_edge;
  logic       pause_edge;
  logic       p1win;
  logic       p2win;
  logic [3:0] re_secs;

  // Key history resets high so a key held through reset never looks like a press.
  assign start_edge  = start_key & ~start_q;
  assign pause_edge  = pause_key & ~pause_q;
  assign p1win       = (numOfDeath2 >= DEATH_LIM) | (numOfgold1 >= GOLD_LIM);
  assign p2win       = (numOfDeath1 >= DEATH_LIM) | (numOfgold2 >= GOLD_LIM);
  assign play_enable = (phase == PLAY);

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q      <= 1'b1;
      pause_q      <= 1'b1;
      phase        <= IDLE;
      clear_scores <= 1'b0;
      countdown    <= 2'd0;
      round_wins1  <= 2'd0;
      round_wins2  <= 2'd0;
      round_winner <= 2'd0;
      game_winner  <= 2'd0;
      re_secs      <= 4'd0;
    end else begin
      start_q      <= start_key;
      pause_q      <= pause_key;
      clear_scores <= 1'b0;
      case (phase)
        IDLE: begin
          if (start_edge) begin
            phase        <= COUNTDOWN;
            countdown    <= CD_INIT;
            clear_scores <= 1'b1;
            round_wins1  <= 2'd0;
            round_wins2  <= 2'd0;
            round_winner <= 2'd0;
            game_winner  <= 2'd0;
          end
        end
        COUNTDOWN: begin
          if (tick_1s) begin
            countdown <= countdown - 2'd1;
            if (countdown == 2'd1) phase <= PLAY;
          end
        end
        PLAY: begin
          // Round resolution wins over a pause press in the same cycle.
          if (p1win || p2win) begin
            phase   <= ROUND_END;
            re_secs <= 4'd0;
            if (p1win && p2win) begin
              round_winner <= 2'd3;
            end else if (p1win) begin
              round_winner <= 2'd1;
              round_wins1  <= sat_inc(round_wins1);
            end else begin
              round_winner <= 2'd2;
              round_wins2  <= sat_inc(round_wins2);
            end
          end else if (pause_edge) begin
            phase <= PAUSE;
          end
        end
        PAUSE: begin
          if (pause_edge) phase <= PLAY;
        end
        ROUND_END: begin
          if (tick_1s) begin
            if (re_secs == RE_LAST) begin
              re_secs <= 4'd0;
              if (round_wins1 >= WINS_LIM) begin
                phase       <= GAME_OVER;
                game_winner <= 2'd1;
              end else if (round_wins2 >= WINS_LIM) begin
                phase       <= GAME_OVER;
                game_winner <= 2'd2;
              end else begin
                phase        <= COUNTDOWN;
                countdown    <= CD_INIT;
                clear_scores <= 1'b1;
                round_winner <= 2'd0;
              end
            end else begin
              re_secs <= re_secs + 4'd1;
            end
          end
        end
        GAME_OVER: begin
          if (start_edge) phase <= IDLE;
        end
        default: phase <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed match walk-through plus randomized
// traffic, every cycle compared against a behavioural phase model.
module tb_game_flow_controller;

  localparam int MAXD = 3;
  localparam int GOLD = 5;
  localparam int CDS  = 3;
  localparam int RES  = 2;
  localparam int RTW  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_key = 1'b0;
  logic       pause_key = 1'b0;
  logic       tick_1s = 1'b0;
  logic [1:0] d1 = 2'd0;
  logic [1:0] d2 = 2'd0;
  logic [2:0] g1 = 3'd0;
  logic [2:0] g2 = 3'd0;
  logic [2:0] phase;
  logic       play_enable;
  logic       clear_scores;
  logic [1:0] countdown;
  logic [1:0] round_wins1;
  logic [1:0] round_wins2;
  logic [1:0] round_winner;
  logic [1:0] game_winner;

  int total = 0;
  int bad = 0;

  // Reference model state (plain integers, phase numbers as published).
  int m_phase = 0, m_cd = 0, m_w1 = 0, m_w2 = 0, m_rw = 0, m_gw = 0;
  int m_clr = 0, m_secs_left = 0;
  bit m_sq = 1'b1, m_pq = 1'b1;

  game_flow_controller #(
    .MAX_DEATHS(MAXD), .GOLD_TO_WIN(GOLD), .COUNTDOWN_SEC(CDS),
    .ROUND_END_SEC(RES), .ROUNDS_TO_WIN(RTW)
  ) dut (
    .clk(clk), .reset(reset), .start_key(start_key), .pause_key(pause_key),
    .tick_1s(tick_1s), .numOfDeath1(d1), .numOfDeath2(d2),
    .numOfgold1(g1), .numOfgold2(g2), .phase(phase),
    .play_enable(play_enable), .clear_scores(clear_scores),
    .countdown(countdown), .round_wins1(round_wins1),
    .round_wins2(round_wins2), .round_winner(round_winner),
    .game_winner(game_winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic enter_countdown();
    m_phase = 1;
    m_cd    = CDS;
    m_clr   = 1;
  endtask

  task automatic model_step();
    bit se, pe, p1, p2;
    se = start_key && !m_sq;
    pe = pause_key && !m_pq;
    m_clr = 0;
    if (reset) begin
      m_phase = 0; m_cd = 0; m_w1 = 0; m_w2 = 0; m_rw = 0; m_gw = 0;
      m_secs_left = 0; m_sq = 1'b1; m_pq = 1'b1;
      return;
    end
    m_sq = start_key;
    m_pq = pause_key;
    case (m_phase)
      0: if (se) begin
        enter_countdown();
        m_w1 = 0; m_w2 = 0; m_rw = 0; m_gw = 0;
      end
      1: if (tick_1s) begin
        m_cd = m_cd - 1;
        if (m_cd == 0) m_phase = 2;
      end
      2: begin
        p1 = (int'(d2) >= MAXD) || (int'(g1) >= GOLD);
        p2 = (int'(d1) >= MAXD) || (int'(g2) >= GOLD);
        if (p1 || p2) begin
          m_phase = 4;
          m_secs_left = RES;
          if (p1 && p2) m_rw = 3;
          else if (p1) begin m_rw = 1; if (m_w1 < 3) m_w1++; end
          else begin m_rw = 2; if (m_w2 < 3) m_w2++; end
        end else if (pe) m_phase = 3;
      end
      3: if (pe) m_phase = 2;
      4: if (tick_1s) begin
        m_secs_left--;
        if (m_secs_left == 0) begin
          if (m_w1 >= RTW) begin m_phase = 5; m_gw = 1; end
          else if (m_w2 >= RTW) begin m_phase = 5; m_gw = 2; end
          else begin enter_countdown(); m_rw = 0; end
        end
      end
      5: if (se) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("phase", int'(phase), m_phase);
    check("play_enable", int'(play_enable), (m_phase == 2) ? 1 : 0);
    check("clear_scores", int'(clear_scores), m_clr);
    check("countdown", int'(countdown), m_cd);
    check("round_wins1", int'(round_wins1), m_w1);
    check("round_wins2", int'(round_wins2), m_w2);
    check("round_winner", int'(round_winner), m_rw);
    check("game_winner", int'(game_winner), m_gw);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic tick_pulse();
    tick_1s = 1'b1; cycle();
    tick_1s = 1'b0; cycle();
  endtask

  task automatic clear_inputs();
    d1 = 2'd0; d2 = 2'd0; g1 = 3'd0; g2 = 3'd0;
  endtask

  task automatic to_play();
    tick_pulse(); tick_pulse(); tick_pulse();
  endtask

  initial begin
    // Reset with start held high: no transition afterwards.
    reset = 1'b1; start_key = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(10);
    check("idle_phase_held_start", int'(phase), 0);
    check("idle_outputs", int'({play_enable, clear_scores, countdown, game_winner}), 0);
    start_key = 1'b0;
    cycle();

    // Start and countdown.
    start_key = 1'b1; cycle();
    check("start_phase", int'(phase), 1);
    check("start_clear", int'(clear_scores), 1);
    check("start_cd", int'(countdown), 3);
    start_key = 1'b0; cycle();
    check("clear_one_cycle", int'(clear_scores), 0);
    tick_1s = 1'b1; cycle(); check("cd_2", int'(countdown), 2);
    tick_1s = 1'b0; cycle();
    tick_1s = 1'b1; cycle(); check("cd_1", int'(countdown), 1);
    tick_1s = 1'b0; cycle();
    tick_1s = 1'b1; cycle();
    check("play_after_3", int'(phase), 2);
    check("play_en", int'(play_enable), 1);
    tick_1s = 1'b0; cycles(3);

    // Tank 2 killed three times: tank 1 takes the round.
    d2 = 2'd3; cycle();
    check("p1_round_phase", int'(phase), 4);
    check("p1_round_winner", int'(round_winner), 1);
    check("p1_round_wins", int'(round_wins1), 1);
    check("p1_play_drop", int'(play_enable), 0);
    clear_inputs();
    tick_1s = 1'b1; cycle(); tick_1s = 1'b0; cycle();
    tick_1s = 1'b1; cycle();
    check("re_to_cd", int'(phase), 1);
    check("re_clear", int'(clear_scores), 1);
    tick_1s = 1'b0; cycle();
    to_play();

    // Draw.
    g1 = 3'd5; d1 = 2'd3; cycle();
    check("draw_winner", int'(round_winner), 3);
    check("draw_w1", int'(round_wins1), 1);
    check("draw_w2", int'(round_wins2), 0);
    clear_inputs();
    tick_pulse(); tick_pulse();
    to_play();

    // Pause freezes scoring.
    pause_key = 1'b1; cycle();
    check("pause_phase", int'(phase), 3);
    check("pause_play_en", int'(play_enable), 0);
    d1 = 2'd3; cycles(3);
    check("pause_ignores", int'(phase), 3);
    pause_key = 1'b0; cycle();
    pause_key = 1'b1; cycle();
    check("resume", int'(phase), 2);
    cycle();
    check("p2_round", int'(round_winner), 2);
    check("p2_round_phase", int'(phase), 4);
    pause_key = 1'b0; clear_inputs();
    tick_pulse(); tick_pulse();
    to_play();

    // Tank 1 second round win ends the game.
    g1 = 3'd6; cycle();
    check("w1_two", int'(round_wins1), 2);
    clear_inputs();
    tick_pulse(); tick_pulse();
    check("game_over", int'(phase), 5);
    check("game_winner", int'(game_winner), 1);
    cycles(4);
    start_key = 1'b1; cycle();
    check("go_to_idle", int'(phase), 0);
    check("idle_hold_w1", int'(round_wins1), 2);
    start_key = 1'b0; cycles(3);
    start_key = 1'b1; cycle();
    check("restart_w1", int'(round_wins1), 0);
    check("restart_gw", int'(game_winner), 0);
    start_key = 1'b0; cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(399) == 0);
      tick_1s   = ($urandom_range(4) == 0);
      if ($urandom_range(7) == 0) start_key = ~start_key;
      if ($urandom_range(9) == 0) pause_key = ~pause_key;
      if ($urandom_range(24) == 0) d1 = 2'($urandom_range(3));
      if ($urandom_range(24) == 0) d2 = 2'($urandom_range(3));
      if ($urandom_range(24) == 0) g1 = 3'($urandom_range(7));
      if ($urandom_range(24) == 0) g2 = 3'($urandom_range(7));
      cycle();
      if (m_clr != 0) clear_inputs();
    end
    reset = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
